// File: rtl/reloj_pkg.sv
// ---------------------------------------------------------------------------
// reloj_pkg
// Shared definitions for the RTC field decoders (seconds, minutes, hours).
//   estado_t : decoder FSM states
//   SEG_MAX, MIN_MAX, HORA_MAX : highest legal decoded value per field
// ---------------------------------------------------------------------------
package reloj_pkg;

    typedef enum logic [2:0] {
        REPOSO    = 3'd0,
        VERIFICA  = 3'd1,
        CONVIERTE = 3'd2,
        ENTREGA   = 3'd3,
        RECHAZO   = 3'd4
    } estado_t;

    localparam int SEG_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HORA_MAX = 23;

endpackage

// File: rtl/decodificador_segundos_bcd_if.sv
// ---------------------------------------------------------------------------
// decodificador_segundos_bcd_if
// Bus between the RTC register reader (master) and a BCD field decoder
// (slave).
//   datos_in    : packed BCD byte, [7:4] tens, [3:0] units   (master -> slave)
//   dato_valido : one-cycle strobe qualifying datos_in       (master -> slave)
//   listo       : decoder will accept a strobe this cycle    (slave -> master)
//   seg_bin     : last good decoded value, N bits            (slave -> master)
//   seg_valido  : pulse, seg_bin updated                     (slave -> master)
//   cambio      : pulse with seg_valido, value changed       (slave -> master)
//   error_bcd   : pulse, byte rejected                       (slave -> master)
//   sobrecarga  : sticky overrun flag                        (slave -> master)
//   cuenta_err  : saturating error count, ERR_W bits         (slave -> master)
// ---------------------------------------------------------------------------
interface decodificador_segundos_bcd_if #(
    parameter int N     = 6,
    parameter int ERR_W = 8
) ();

    logic [7:0]       datos_in;
    logic             dato_valido;
    logic             listo;
    logic [N-1:0]     seg_bin;
    logic             seg_valido;
    logic             cambio;
    logic             error_bcd;
    logic             sobrecarga;
    logic [ERR_W-1:0] cuenta_err;

    modport master (
        output datos_in, dato_valido,
        input  listo, seg_bin, seg_valido, cambio, error_bcd, sobrecarga, cuenta_err
    );

    modport slave (
        input  datos_in, dato_valido,
        output listo, seg_bin, seg_valido, cambio, error_bcd, sobrecarga, cuenta_err
    );

endinterface

// File: rtl/decodificador_segundos_bcd_bcd_a_bin.sv
// ---------------------------------------------------------------------------
// bcd_a_bin
// Combinational packed-BCD to binary converter with range check. Reusable
// for the seconds, minutes and hours decoders through MAX_VAL.
//   bcd   : packed BCD input, [7:4] tens, [3:0] units
//   legal : both digits <= 9 and the decoded value <= MAX_VAL
//   bin   : decoded value truncated to N bits (meaningful only when legal)
// ---------------------------------------------------------------------------
module bcd_a_bin #(
    parameter int MAX_VAL = 59,
    parameter int N       = 6
) (
    input  logic [7:0]   bcd,
    output logic         legal,
    output logic [N-1:0] bin
);

    localparam logic [7:0] MAX_B = 8'(MAX_VAL);

    logic [3:0] decenas;
    logic [3:0] unidades;
    logic [7:0] valor;

    assign decenas  = bcd[7:4];
    assign unidades = bcd[3:0];

    // tens*10 as (tens<<3) + (tens<<1). Kept 8 bits wide so that illegal
    // digits (up to 15*10+15) cannot alias into the legal range.
    assign valor = {1'b0, decenas, 3'b000}
                 + {3'b000, decenas, 1'b0}
                 + {4'b0000, unidades};

    assign legal = (decenas <= 4'd9) && (unidades <= 4'd9) && (valor <= MAX_B);
    assign bin   = valor[N-1:0];

endmodule

// File: rtl/decodificador_segundos_bcd.sv
// ---------------------------------------------------------------------------
// decodificador_segundos_bcd
// Receive-side decoder for the RTC seconds field. Validates the packed BCD
// byte, converts it to binary, holds the last good value and flags changes,
// rejections and overruns. All outputs are registered.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : slave side of decodificador_segundos_bcd_if (see interface)
// Timing: strobe in cycle T -> seg_valido in T+3 (listo back in T+4), or
// error_bcd in T+2 (listo back in T+3).
// ---------------------------------------------------------------------------
module decodificador_segundos_bcd
    import reloj_pkg::*;
#(
    parameter int MAX_VAL = SEG_MAX,
    parameter int N       = 6,
    parameter int ERR_W   = 8
) (
    input  logic clk,
    input  logic reset,
    decodificador_segundos_bcd_if.slave bus
);

    estado_t          estado;
    estado_t          estado_sig;

    logic [7:0]       captura;
    logic             legal;
    logic [N-1:0]     bin_conv;

    logic             listo_q;
    logic [N-1:0]     seg_bin_q;
    logic [N-1:0]     previo_q;
    logic             seg_valido_q;
    logic             cambio_q;
    logic             error_q;
    logic             sobrecarga_q;
    logic [ERR_W-1:0] cuenta_q;

    logic             sobre_evt;
    logic             rechazo_evt;

    function automatic logic [ERR_W-1:0] inc_sat(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    bcd_a_bin #(
        .MAX_VAL (MAX_VAL),
        .N       (N)
    ) u_conv (
        .bcd   (captura),
        .legal (legal),
        .bin   (bin_conv)
    );

    // listo_q mirrors (estado == REPOSO), so a strobe seen while it is low
    // is an overrun and never disturbs the byte in flight.
    assign sobre_evt   = bus.dato_valido && !listo_q;
    assign rechazo_evt = (estado == VERIFICA) && !legal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado <= REPOSO;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:    if (bus.dato_valido) estado_sig = VERIFICA;
            VERIFICA:  estado_sig = legal ? CONVIERTE : RECHAZO;
            CONVIERTE: estado_sig = ENTREGA;
            ENTREGA:   estado_sig = REPOSO;
            RECHAZO:   estado_sig = REPOSO;
            default:   estado_sig = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            captura      <= '0;
            listo_q      <= 1'b1;
            seg_bin_q    <= '0;
            previo_q     <= '0;
            seg_valido_q <= 1'b0;
            cambio_q     <= 1'b0;
            error_q      <= 1'b0;
            sobrecarga_q <= 1'b0;
            cuenta_q     <= '0;
        end else begin
            listo_q      <= (estado_sig == REPOSO);
            // Pulses are registered one state early so they are high exactly
            // while the FSM sits in ENTREGA / RECHAZO.
            seg_valido_q <= (estado == CONVIERTE);
            cambio_q     <= (estado == CONVIERTE) && (bin_conv != previo_q);
            error_q      <= rechazo_evt;

            if ((estado == REPOSO) && bus.dato_valido) begin
                captura <= bus.datos_in;
            end

            if (estado == CONVIERTE) begin
                seg_bin_q <= bin_conv;
                previo_q  <= bin_conv;
            end

            if (sobre_evt) begin
                sobrecarga_q <= 1'b1;
            end

            // A rejection and an overrun on the same edge count once.
            if (sobre_evt || rechazo_evt) begin
                cuenta_q <= inc_sat(cuenta_q);
            end
        end
    end

    assign bus.listo      = listo_q;
    assign bus.seg_bin    = seg_bin_q;
    assign bus.seg_valido = seg_valido_q;
    assign bus.cambio     = cambio_q;
    assign bus.error_bcd  = error_q;
    assign bus.sobrecarga = sobrecarga_q;
    assign bus.cuenta_err = cuenta_q;

endmodule

// File: tb/tb_decodificador_segundos_bcd.sv
// ---------------------------------------------------------------------------
// tb_decodificador_segundos_bcd
// Three decoders share one stimulus stream:
//   u0 : seconds, MAX_VAL=59, N=6, ERR_W=8
//   u1 : hours,   MAX_VAL=23, N=5, ERR_W=8
//   u2 : seconds, MAX_VAL=59, N=6, ERR_W=2 (fast error-counter saturation)
// Each is checked every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_decodificador_segundos_bcd;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] d = 8'h00;
    int         k = 0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) k <= k + 1;

    decodificador_segundos_bcd_if #(.N(6), .ERR_W(8)) b0 ();
    decodificador_segundos_bcd_if #(.N(5), .ERR_W(8)) b1 ();
    decodificador_segundos_bcd_if #(.N(6), .ERR_W(2)) b2 ();

    assign b0.datos_in = d;  assign b0.dato_valido = dv;
    assign b1.datos_in = d;  assign b1.dato_valido = dv;
    assign b2.datos_in = d;  assign b2.dato_valido = dv;

    decodificador_segundos_bcd #(.MAX_VAL(59), .N(6), .ERR_W(8)) u0 (
        .clk(clk), .reset(reset), .bus(b0));
    decodificador_segundos_bcd #(.MAX_VAL(23), .N(5), .ERR_W(8)) u1 (
        .clk(clk), .reset(reset), .bus(b1));
    decodificador_segundos_bcd #(.MAX_VAL(59), .N(6), .ERR_W(2)) u2 (
        .clk(clk), .reset(reset), .bus(b2));

    logic o_lis[3], o_sv[3], o_cam[3], o_err[3], o_sob[3];
    int   o_bin[3], o_cnt[3];

    always_comb begin
        o_lis[0] = b0.listo;      o_lis[1] = b1.listo;      o_lis[2] = b2.listo;
        o_sv[0]  = b0.seg_valido; o_sv[1]  = b1.seg_valido; o_sv[2]  = b2.seg_valido;
        o_cam[0] = b0.cambio;     o_cam[1] = b1.cambio;     o_cam[2] = b2.cambio;
        o_err[0] = b0.error_bcd;  o_err[1] = b1.error_bcd;  o_err[2] = b2.error_bcd;
        o_sob[0] = b0.sobrecarga; o_sob[1] = b1.sobrecarga; o_sob[2] = b2.sobrecarga;
        o_bin[0] = int'(b0.seg_bin);    o_bin[1] = int'(b1.seg_bin);    o_bin[2] = int'(b2.seg_bin);
        o_cnt[0] = int'(b0.cuenta_err); o_cnt[1] = int'(b1.cuenta_err); o_cnt[2] = int'(b2.cuenta_err);
    end

    // Reference model: per-instance schedule of when the decoder is free
    // again and when its result / rejection pulse is due.
    int maxv[3] = '{59, 23, 59};
    int cmax[3] = '{255, 255, 3};
    int ready_at[3], valid_at[3], err_at[3], pend[3], e_bin[3], e_cnt[3];
    bit e_sob[3], ovr[3], lis_e[3];

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            ready_at[i] = k; valid_at[i] = -1; err_at[i] = -1; pend[i] = 0;
            e_bin[i] = 0; e_cnt[i] = 0; e_sob[i] = 1'b0; ovr[i] = 1'b0;
        end
    endtask

    task automatic check_reset();
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("u%0d.rst.listo", i), int'(o_lis[i]), 1);
            check_val($sformatf("u%0d.rst.seg_valido", i), int'(o_sv[i]), 0);
            check_val($sformatf("u%0d.rst.cambio", i), int'(o_cam[i]), 0);
            check_val($sformatf("u%0d.rst.error_bcd", i), int'(o_err[i]), 0);
            check_val($sformatf("u%0d.rst.seg_bin", i), o_bin[i], 0);
            check_val($sformatf("u%0d.rst.sobrecarga", i), int'(o_sob[i]), 0);
            check_val($sformatf("u%0d.rst.cuenta_err", i), o_cnt[i], 0);
        end
    endtask

    task automatic check_cycle();
        for (int i = 0; i < 3; i++) begin
            bit sv_e, cam_e, er_e;
            if ((k == err_at[i]) || ovr[i])
                e_cnt[i] = (e_cnt[i] < cmax[i]) ? e_cnt[i] + 1 : e_cnt[i];
            if (ovr[i]) e_sob[i] = 1'b1;
            ovr[i] = 1'b0;
            sv_e  = (k == valid_at[i]);
            cam_e = 1'b0;
            if (sv_e) begin
                cam_e    = (pend[i] != e_bin[i]);
                e_bin[i] = pend[i];
            end
            er_e     = (k == err_at[i]);
            lis_e[i] = (k >= ready_at[i]);
            check_val($sformatf("u%0d.listo@%0d", i, k), int'(o_lis[i]), int'(lis_e[i]));
            check_val($sformatf("u%0d.seg_valido@%0d", i, k), int'(o_sv[i]), int'(sv_e));
            check_val($sformatf("u%0d.cambio@%0d", i, k), int'(o_cam[i]), int'(cam_e));
            check_val($sformatf("u%0d.error_bcd@%0d", i, k), int'(o_err[i]), int'(er_e));
            check_val($sformatf("u%0d.seg_bin@%0d", i, k), o_bin[i], e_bin[i]);
            check_val($sformatf("u%0d.sobrecarga@%0d", i, k), int'(o_sob[i]), int'(e_sob[i]));
            check_val($sformatf("u%0d.cuenta_err@%0d", i, k), o_cnt[i], e_cnt[i]);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then drive this cycle's input.
    task automatic step(input bit v, input logic [7:0] x);
        int tens, units, val;
        @(negedge clk);
        check_cycle();
        dv = v;
        d  = x;
        if (v) begin
            tens  = int'(x[7:4]);
            units = int'(x[3:0]);
            val   = tens * 10 + units;
            for (int i = 0; i < 3; i++) begin
                if (!lis_e[i]) begin
                    ovr[i] = 1'b1;
                end else if (tens <= 9 && units <= 9 && val <= maxv[i]) begin
                    pend[i]     = val;
                    valid_at[i] = k + 3;
                    ready_at[i] = k + 4;
                end else begin
                    err_at[i]   = k + 2;
                    ready_at[i] = k + 3;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        dv    = 1'b0;
        d     = 8'h00;
        #1 check_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        reset = 1'b1;
        model_reset();
    endtask

    logic [7:0] dirigidos[8] = '{8'h37, 8'h37, 8'h59, 8'h00, 8'h60, 8'h1A, 8'h23, 8'h24};

    initial begin
        logic [7:0] x;
        logic [7:0] ultimo;
        bit         v;
        int         sel;

        do_reset();

        // Directed bytes, spaced so every decoder is idle again.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, dirigidos[i]);
            idle(5);
        end

        // Overrun: second strobe one cycle after the first.
        step(1'b1, 8'h12);
        step(1'b1, 8'h45);
        idle(5);

        // Strobe held every cycle.
        for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom_range(0, 89)));
        idle(5);

        // Reset during conversion, then decode again.
        step(1'b1, 8'h25);
        step(1'b0, 8'h00);
        do_reset();
        step(1'b1, 8'h25);
        idle(5);

        // Randomized traffic.
        ultimo = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                x = ultimo;
            else if (sel < 7)
                x = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 9))};
            else
                x = 8'($urandom);
            v = ($urandom_range(0, 9) < 4);
            if (v) ultimo = x;
            step(v, x);
        end
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
